// File: rtl/axi4s_uart_pkg.sv
// Shared types and default framing bytes for the UART byte-stream deframer.
package axi4s_uart_pkg;

    typedef enum logic [1:0] {IDLE, BODY, ESC, DISCARD} deframer_state_t;

    localparam logic [7:0] DEF_START_BYTE  = 8'h7E;
    localparam logic [7:0] DEF_STOP_BYTE   = 8'h7F;
    localparam logic [7:0] DEF_ESCAPE_BYTE = 8'h7D;

    typedef struct packed {
        logic [7:0] tdata;
        logic       tlast;
        logic       tuser;
    } pkt_beat_t;

endpackage

// File: rtl/axi4s_uart_deframer_if.sv
// Byte-in / packet-out stream bundle of the deframer; m_pkt_tid exists only
// when AXI4S_DEFRAMER_TID_EN is defined.
interface axi4s_uart_deframer_if;

    logic       s_byte_tvalid;
    logic       s_byte_tready;
    logic [7:0] s_byte_tdata;
    logic       m_pkt_tvalid;
    logic       m_pkt_tready;
    logic [7:0] m_pkt_tdata;
    logic       m_pkt_tlast;
    logic       m_pkt_tuser;
`ifdef AXI4S_DEFRAMER_TID_EN
    logic [7:0] m_pkt_tid;

    modport slave (
        input  s_byte_tvalid, s_byte_tdata, m_pkt_tready,
        output s_byte_tready, m_pkt_tvalid, m_pkt_tdata, m_pkt_tlast, m_pkt_tuser, m_pkt_tid
    );
    modport master (
        output s_byte_tvalid, s_byte_tdata, m_pkt_tready,
        input  s_byte_tready, m_pkt_tvalid, m_pkt_tdata, m_pkt_tlast, m_pkt_tuser, m_pkt_tid
    );
`else
    modport slave (
        input  s_byte_tvalid, s_byte_tdata, m_pkt_tready,
        output s_byte_tready, m_pkt_tvalid, m_pkt_tdata, m_pkt_tlast, m_pkt_tuser
    );
    modport master (
        output s_byte_tvalid, s_byte_tdata, m_pkt_tready,
        input  s_byte_tready, m_pkt_tvalid, m_pkt_tdata, m_pkt_tlast, m_pkt_tuser
    );
`endif

endinterface

// File: rtl/axi4s_deframer_outreg.sv
// Single-entry AXI4-Stream output register; accepts a push in the same cycle
// the current beat drains, so it sustains one beat per cycle.
module axi4s_deframer_outreg
    import axi4s_uart_pkg::*;
(
    input  logic      aclk,
    input  logic      areset,
    input  logic      push_valid_i,
    input  pkt_beat_t push_beat_i,
    output logic      ready_o,
    output logic      m_tvalid_o,
    input  logic      m_tready_i,
    output pkt_beat_t m_beat_o
);

    logic      valid_q, valid_d;
    pkt_beat_t beat_q, beat_d;

    assign ready_o    = !valid_q || m_tready_i;
    assign m_tvalid_o = valid_q;
    assign m_beat_o   = beat_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (push_valid_i) begin
            valid_d = 1'b1;
            beat_d  = push_beat_i;
        end else if (m_tready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/axi4s_uart_deframer.sv
// START/STOP/ESCAPE byte-stream deframer producing AXI4-Stream packets.
// Optional packet id on m_pkt_tid: define AXI4S_DEFRAMER_TID_EN.
module axi4s_uart_deframer
    import axi4s_uart_pkg::*;
#(
    parameter logic [7:0]  START_BYTE  = DEF_START_BYTE,
    parameter logic [7:0]  STOP_BYTE   = DEF_STOP_BYTE,
    parameter logic [7:0]  ESCAPE_BYTE = DEF_ESCAPE_BYTE,
    parameter int unsigned MAX_LEN     = 256
) (
    input logic                   aclk,
    input logic                   areset,
    axi4s_uart_deframer_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    typedef logic [LEN_W-1:0] len_t;
    localparam len_t LEN_MAX = len_t'(MAX_LEN);

    deframer_state_t state_q, state_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_valid_q, hold_valid_d;
    len_t            len_q, len_d;
    logic            disc_esc_q, disc_esc_d;

    logic       out_ready;
    logic       accept;
    logic [7:0] in_byte;
    logic       is_payload;
    logic       take_id;
    logic       push_valid;
    pkt_beat_t  push_beat;
    pkt_beat_t  out_beat;

`ifdef AXI4S_DEFRAMER_TID_EN
    logic       id_pending_q, id_pending_d;
    logic [7:0] frame_tid_q, frame_tid_d;
    logic [7:0] tid_q;
    assign take_id = id_pending_q;
`else
    assign take_id = 1'b0;
`endif

    assign bus.s_byte_tready = out_ready;
    assign accept  = bus.s_byte_tvalid && out_ready;
    assign in_byte = bus.s_byte_tdata;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        len_d        = len_q;
        disc_esc_d   = disc_esc_q;
        is_payload   = 1'b0;
        push_valid   = 1'b0;
        push_beat    = '0;
`ifdef AXI4S_DEFRAMER_TID_EN
        id_pending_d = id_pending_q;
        frame_tid_d  = frame_tid_q;
`endif
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_byte == START_BYTE) begin
                        state_d = BODY;
                        len_d   = '0;
`ifdef AXI4S_DEFRAMER_TID_EN
                        id_pending_d = 1'b1;
`endif
                    end
                end
                BODY: begin
                    if (in_byte == ESCAPE_BYTE) begin
                        state_d = ESC;
                    end else if (in_byte == STOP_BYTE || in_byte == START_BYTE) begin
                        // STOP closes cleanly; an unescaped START aborts and reopens.
                        push_valid   = hold_valid_q;
                        push_beat    = '{tdata: hold_q, tlast: 1'b1, tuser: (in_byte == START_BYTE)};
                        hold_valid_d = 1'b0;
                        len_d        = '0;
                        state_d      = (in_byte == STOP_BYTE) ? IDLE : BODY;
`ifdef AXI4S_DEFRAMER_TID_EN
                        id_pending_d = (in_byte == START_BYTE);
`endif
                    end else begin
                        is_payload = 1'b1;
                    end
                end
                ESC: begin
                    state_d    = BODY;
                    is_payload = 1'b1;
                end
                DISCARD: begin
                    if (disc_esc_q) begin
                        disc_esc_d = 1'b0;
                    end else if (in_byte == ESCAPE_BYTE) begin
                        disc_esc_d = 1'b1;
                    end else if (in_byte == STOP_BYTE) begin
                        state_d = IDLE;
                    end else if (in_byte == START_BYTE) begin
                        state_d = BODY;
                        len_d   = '0;
`ifdef AXI4S_DEFRAMER_TID_EN
                        id_pending_d = 1'b1;
`endif
                    end
                end
            endcase
        end

        if (is_payload) begin
            if (take_id) begin
`ifdef AXI4S_DEFRAMER_TID_EN
                frame_tid_d  = in_byte;
                id_pending_d = 1'b0;
`endif
            end else if (len_q == LEN_MAX) begin
                push_valid   = 1'b1;
                push_beat    = '{tdata: hold_q, tlast: 1'b1, tuser: 1'b1};
                hold_valid_d = 1'b0;
                disc_esc_d   = 1'b0;
                state_d      = DISCARD;
            end else begin
                push_valid   = hold_valid_q;
                push_beat    = '{tdata: hold_q, tlast: 1'b0, tuser: 1'b0};
                hold_d       = in_byte;
                hold_valid_d = 1'b1;
                len_d        = len_q + len_t'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            len_q        <= '0;
            disc_esc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            len_q        <= len_d;
            disc_esc_q   <= disc_esc_d;
        end
    end

`ifdef AXI4S_DEFRAMER_TID_EN
    // tid is loaded together with each beat so it cannot change under a stalled beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            id_pending_q <= 1'b0;
            frame_tid_q  <= '0;
            tid_q        <= '0;
        end else begin
            id_pending_q <= id_pending_d;
            frame_tid_q  <= frame_tid_d;
            if (push_valid) begin
                tid_q <= frame_tid_q;
            end
        end
    end

    assign bus.m_pkt_tid = tid_q;
`endif

    axi4s_deframer_outreg u_outreg (
        .aclk         (aclk),
        .areset       (areset),
        .push_valid_i (push_valid),
        .push_beat_i  (push_beat),
        .ready_o      (out_ready),
        .m_tvalid_o   (bus.m_pkt_tvalid),
        .m_tready_i   (bus.m_pkt_tready),
        .m_beat_o     (out_beat)
    );

    assign bus.m_pkt_tdata = out_beat.tdata;
    assign bus.m_pkt_tlast = out_beat.tlast;
    assign bus.m_pkt_tuser = out_beat.tuser;

endmodule
